// File: rtl/fix2float_packer.sv
// fix2float_packer: four-stage pipeline that turns a signed fixed-point
// sample (W bits, F fractional bits) into an IEEE-754 single-precision word.
// Stages: magnitude, leading-zero count, normalize, round and pack.
// Build option: define FIX2FLOAT_ROUND_EN for round-to-nearest-even;
// otherwise the significand is truncated toward zero.
module fix2float_packer #(
  parameter int W = 32,
  parameter int F = 18
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data
);

  localparam int LZW = $clog2(W + 1);

  // The exponent must always land in the normal range, so no overflow or
  // denormal handling is built; refuse to elaborate otherwise.
  generate
    if (W < 2 || W > 64 || F < 0 || F >= W ||
        (W - 1 - F) + 127 > 254 || 127 - F < 1) begin : gBadParams
      $error("fix2float_packer: unsupported W/F combination");
    end
  endgenerate

  // Count leading zeros from the MSB down; an all-zero word returns W.
  function automatic logic [LZW-1:0] countLz(input logic [W-1:0] value);
    logic [LZW-1:0] count;
    logic           found;
    count = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (value[i]) found = 1'b1;
        else          count = count + LZW'(1);
      end
    end
    return count;
  endfunction

  // Every stage moves together; a stalled output freezes the whole pipe.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic           s1Valid, s1Sign;
  logic [W-1:0]   s1Mag;
  logic           s2Valid, s2Sign, s2Zero;
  logic [W-1:0]   s2Mag;
  logic [LZW-1:0] s2Lzc;
  logic           s3Valid, s3Sign, s3Zero;
  logic [W-1:0]   s3Shifted;
  logic [8:0]     s3Exp;

  logic [W-1:0]   magNext;
  logic [W-1:0]   shiftedNext;
  logic [8:0]     expNext;
  logic [31:0]    packedWord;

  // Stage arithmetic feeding the S1..S3 registers; the negation of the most
  // negative input wraps to 2^(W-1), which is the correct unsigned magnitude.
  always_comb begin
    magNext     = in_data[W-1] ? -in_data : in_data;
    shiftedNext = s2Mag << s2Lzc;
    expNext     = 9'(W + 126 - F - int'(s2Lzc));
  end

  // Round/truncate the normalized magnitude and assemble the float32 word.
  logic [W+23:0] ext;
  logic [23:0]   sig;
  logic [22:0]   frac;
  logic [8:0]    expFinal;
  logic          unusedBits;
`ifdef FIX2FLOAT_ROUND_EN
  logic          guardBit, stickyBit, roundUp;
  logic [24:0]   sum;
`endif

  // Significand selection, optional rounding with carry-out, and packing.
  always_comb begin
    ext      = {s3Shifted, 24'b0};
    sig      = ext[W+23 -: 24];
    frac     = sig[22:0];
    expFinal = s3Exp;
`ifdef FIX2FLOAT_ROUND_EN
    guardBit  = ext[W-1];
    stickyBit = |ext[W-2:0];
    roundUp   = guardBit && (stickyBit || sig[0]);
    sum       = {1'b0, sig} + 25'(roundUp);
    if (sum[24]) begin
      frac     = '0;
      expFinal = s3Exp + 9'd1;
    end else begin
      frac = sum[22:0];
    end
    unusedBits = ^{sum[23], expFinal[8]};
`else
    unusedBits = ^{sig[23], ext[W-1:0], expFinal[8]};
`endif
    packedWord = s3Zero ? 32'h0 : {s3Sign, expFinal[7:0], frac};
  end

  // Valid bits and the output word; reset drops everything in flight.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1Valid   <= 1'b0;
      s2Valid   <= 1'b0;
      s3Valid   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
    end else if (advance) begin
      s1Valid   <= in_valid;
      s2Valid   <= s1Valid;
      s3Valid   <= s2Valid;
      out_valid <= s3Valid;
      if (s3Valid) out_data <= packedWord;
    end
  end

  // Stage data registers; contents are don't-care while their valid is low.
  always_ff @(posedge clock) begin
    if (advance) begin
      s1Sign    <= in_data[W-1];
      s1Mag     <= magNext;
      s2Sign    <= s1Sign;
      s2Mag     <= s1Mag;
      s2Lzc     <= countLz(s1Mag);
      s2Zero    <= (s1Mag == '0);
      s3Sign    <= s2Sign;
      s3Zero    <= s2Zero;
      s3Shifted <= shiftedNext;
      s3Exp     <= expNext;
    end
  end

endmodule

// File: tb/tb_fix2float_packer.sv
// tb_fix2float_packer: directed and randomized checks of fix2float_packer
// against a value-level float32 reference computed with integer arithmetic.
module tb_fix2float_packer;

  localparam int W = 32;
  localparam int F = 18;

  logic         clock = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;

  fix2float_packer #(.W(W), .F(F)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  int          cycleNum = 0;
  logic [31:0] expQ[$];
  int          acceptQ[$];
  bit          latencyCheck = 0;
  bit          prevHeld = 0;
  logic [31:0] prevData = '0;
  logic        lastInReady, lastOutValid, lastAccepted;

  // Float32 encoding of a fixed-point value: find the power of two, scale
  // the magnitude to a 24-bit significand, optionally round to even.
  function automatic logic [31:0] refModel(input logic [W-1:0] d);
    longint v, mag, scaled, sig;
    int e, expField;
    logic [31:0] r;
`ifdef FIX2FLOAT_ROUND_EN
    longint rem, half;
`endif
    v   = longint'($signed(d));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 32'h0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    scaled = mag << 23;
    sig    = scaled >> e;
`ifdef FIX2FLOAT_ROUND_EN
    rem = scaled - (sig << e);
    if (e > 0) begin
      half = longint'(1) << (e - 1);
      if (rem > half || (rem == half && sig[0])) sig++;
    end
`endif
    if (sig == (longint'(1) << 24)) begin
      sig = longint'(1) << 23;
      e++;
    end
    expField = e - F + 127;
    r = {(v < 0), expField[7:0], sig[22:0]};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle from a negedge, score handshakes, advance to next negedge.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                               input logic r, input bit useExp,
                               input logic [31:0] expVal);
    logic [31:0] e;
    int a;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    lastInReady  = in_ready;
    lastOutValid = out_valid;
    if (prevHeld) begin
      checkOutput("holdValid", 32'(out_valid), 32'd1);
      checkOutput("holdData", out_data, prevData);
    end
    if (out_valid === 1'b1 && r) begin
      tests++;
      assert (expQ.size() > 0) else begin
        fails++;
        $error("[TB] FAIL spurious observed=%h expected=none", out_data);
      end
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = acceptQ.pop_front();
        checkOutput("data", out_data, e);
        if (latencyCheck) checkOutput("latency", 32'(cycleNum - a), 32'd4);
      end
    end
    lastAccepted = v && (in_ready === 1'b1) && resetn;
    if (lastAccepted) begin
      expQ.push_back(useExp ? expVal : refModel(d));
      acceptQ.push_back(cycleNum);
    end
    prevHeld = resetn && (out_valid === 1'b1) && !r;
    prevData = out_data;
    if (!resetn) begin
      expQ.delete();
      acceptQ.delete();
    end
    cycleNum++;
    @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expQ.size() > 0; i++)
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);
    tests++;
    assert (expQ.size() == 0) else begin
      fails++;
      $error("[TB] FAIL drain observed=%0d pending expected=0", expQ.size());
    end
  endtask

  initial begin
    logic [W-1:0] dirIn[3];
    logic [31:0]  dirOut[3];
    logic [W-1:0] d;
    int k;

    resetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clock);

    // Reset held: output quiet and zeroed.
    for (int i = 0; i < 4; i++) begin
      checkOutput("rstValid", 32'(out_valid), 32'd0);
      checkOutput("rstData", out_data, 32'h0);
      @(negedge clock);
    end

    // Release with 1.0 and check the 4-cycle latency.
    resetn = 1'b1;
    latencyCheck = 1;
    applyStimulus(1'b1, 32'h00040000, 1'b1, 1'b1, 32'h3F800000);
    drain();

    // Sign, zero and extremes back-to-back.
    applyStimulus(1'b1, 32'hFFFE0000, 1'b1, 1'b1, 32'hBF000000);
    applyStimulus(1'b1, 32'h00000000, 1'b1, 1'b1, 32'h00000000);
    applyStimulus(1'b1, 32'h00000001, 1'b1, 1'b1, 32'h36800000);
    applyStimulus(1'b1, 32'h80000000, 1'b1, 1'b1, 32'hC6000000);
    drain();

    // Rounding or truncation corner values depending on the build.
    dirIn[0] = 32'h01000001; dirIn[1] = 32'h01000003; dirIn[2] = 32'h7FFFFFFF;
`ifdef FIX2FLOAT_ROUND_EN
    dirOut[0] = 32'h42800000; dirOut[1] = 32'h42800002; dirOut[2] = 32'h46000000;
`else
    dirOut[0] = 32'h42800000; dirOut[1] = 32'h42800001; dirOut[2] = 32'h45FFFFFF;
`endif
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, dirIn[i], 1'b1, 1'b1, dirOut[i]);
    drain();

    // Backpressure: 8 incrementing values, out_ready low in cycles 6..9.
    latencyCheck = 0;
    k = 0;
    for (int i = 0; i < 40 && (k < 8 || expQ.size() > 0); i++) begin
      applyStimulus(k < 8, 32'h00040000 + 32'(k), !(i >= 6 && i <= 9),
                    1'b0, 32'h0);
      if (lastAccepted) k++;
      if (i >= 6 && i <= 9) checkOutput("stallReady", 32'(lastInReady), 32'd0);
    end
    checkOutput("bpAccepted", 32'(k), 32'd8);
    drain();

    // Reset mid-flight: three samples discarded, only 1.0 emerges.
    latencyCheck = 1;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 32'h0);
    resetn = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);
    resetn = 1'b1;
    applyStimulus(1'b1, 32'h00040000, 1'b1, 1'b1, 32'h3F800000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);
      checkOutput("flushQuiet", 32'(lastOutValid), 32'd0);
    end
    drain();

    // Randomized traffic with random stalls against the reference model.
    latencyCheck = 0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       d = '0;
        1:       d = 32'h80000000;
        2:       d = 32'($urandom_range(0, 255));
        3:       d = -32'($urandom_range(1, 4096));
        default: d = $urandom;
      endcase
      applyStimulus($urandom_range(0, 99) < 70, d, $urandom_range(0, 99) < 75,
                    1'b0, 32'h0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fix2float_packer.md
Name: fix2float_packer

Overview:
- Pipelined converter from signed Q-format fixed point (default Q13.18, 32-bit) to IEEE-754 single-precision bit patterns.
- Sits on the output side of the activation datapath. Fixed-point tanh/sigmoid/exp results are repacked into the float32 word that leaves `core` on `y`.
- It is the encoding counterpart of the float32-to-fixed decoder on `core`'s `x` input.
- Uses a valid/ready stream with full backpressure. Latency is 4 cycles when not stalled.

Parameters:
- W, 32: input fixed-point width, two's complement.
- F, 18: input fractional bits.
- Legal range: 2 <= W <= 64, 0 <= F < W. The result exponent (W-1-F)+127 must be <= 254 and 127-F must be >= 1, so no overflow or denormal handling exists; the RTL carries an elaboration-time check for this.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  packer accepts in_data this cycle
- in_data  in  W  signed fixed-point value, F fractional bits
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  32  IEEE-754 single bits {sign, exp[7:0], frac[22:0]}

Behaviour:
- Reset: synchronous, active-low, sampled on the rising clock edge.
  - All stage valid bits clear; out_valid=0; out_data=32'h0.
  - Data registers other than out_data are don't-care.
  - Reset mid-operation discards every in-flight sample; no partial output is ever produced.
- Pipeline advance: advance = !out_valid || out_ready; in_ready = advance.
  - All 4 stages shift together only when advance=1; otherwise every stage holds (data and valid).
  - out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
  - A transfer happens when in_valid && in_ready. Bubbles propagate as valid=0 stages.
- S1 (magnitude): sign = in_data[W-1]; mag = sign ? -in_data : in_data, as a W-bit unsigned value.
  - The most negative input -2^(W-1) gives mag = 2^(W-1) and must be correct.
- S2 (leading-zero count): lzc over mag, W bits. zero flag = (mag==0).
- S3 (normalize): shifted = mag << lzc, so the MSB sits at bit W-1. exp_raw = (W-1-lzc) - F + 127.
- S4 (round and pack):
  - Take the 24-bit significand from shifted[W-1:W-24], zero-extended on the right when W<24.
  - Rounding per the optional feature.
  - If rounding carries out to 2^24: significand = 2^23 and exp_raw+1.
  - out_data = {sign, exp[7:0], sig[22:0]}.
  - Zero input gives 32'h00000000 (+0.0, never -0.0).
- Latency: an accepted sample appears on out_data exactly 4 advancing cycles later. Throughput is 1 sample per clock while out_ready=1.
- Simultaneous out-handshake and in-handshake in the same cycle: both occur, with no bubble inserted.

Optional Feature:
- Macro: FIX2FLOAT_ROUND_EN.
- Defined: round-to-nearest-even in S4.
  - guard = shifted[W-25]; sticky = OR of shifted[W-26:0].
  - Round up when guard && (sticky || sig[0]).
- Undefined: truncation toward zero of the magnitude. Guard and sticky logic is not synthesized; latency is unchanged at 4.

Test Plan:
- Reset and basic conversion, out_ready=1:
  - Hold resetn=0 for 4 cycles, then release with in_data=32'h00040000 (1.0) → 4 cycles later out_valid=1, out_data=32'h3F800000.
  - During reset, out_valid=0 and out_data=0.
- Sign, zero and extremes, back-to-back stream:
  - 32'hFFFE0000 (-0.5) → 32'hBF000000.
  - 32'h00000000 → 32'h00000000.
  - 32'h00000001 (2^-18) → 32'h36800000.
  - 32'h80000000 (-8192) → 32'hC6000000.
  - All four emerge on consecutive cycles.
- Rounding, FIX2FLOAT_ROUND_EN defined:
  - 32'h01000001 → 32'h42800000 (tie to even).
  - 32'h01000003 → 32'h42800002.
  - 32'h7FFFFFFF → 32'h46000000 (carry-out bumps the exponent).
- Truncation, macro undefined: 32'h7FFFFFFF → 32'h45FFFFFF; 32'h01000003 → 32'h42800001.
- Backpressure: stream 8 incrementing values, with out_ready low for cycles 6–9.
  - in_ready=0 in those cycles; out_data is held stable.
  - All 8 outputs arrive in order, with no loss or duplication.
- Reset mid-flight: accept 3 samples, assert resetn=0 for 1 cycle on the next edge, then feed 32'h00040000.
  - Only 32'h3F800000 is produced, 4 cycles after acceptance.
  - out_valid stays 0 throughout until then.
